// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: round-robin arbiter and sequencer in front of a shared
// 4:1 lane multiplexer. It picks one of four requesters, drives the mux
// select and registers the chosen lane for a valid/ready consumer.
//
// Latency: a request seen in cycle N is presented on out_valid/out_data in
// cycle N+1. A new lane can be taken every cycle while out_ready is high.
// Backpressure: with out_valid=1 and out_ready=0 the output is held stable
// and no grant is issued. The arbiter only takes a lane when idle or when
// the held word is being accepted in the same cycle.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req[3:0]   per-lane request
//   data_in    four packed lanes; lane i = data_in[i*WIDTH +: WIDTH]
//   lock[3:0]  (only with RR_MUX_ARBITER_LOCK_EN) keep the winner granted
//   gnt[3:0]   one-hot grant, combinational, high in the capture cycle
//   sel[1:0]   registered index of the lane held at the output
//   out_valid  registered, output holds a captured transfer
//   out_data   registered captured lane data
//   out_ready  consumer accepts out_data when out_valid && out_ready
//
// Optional feature macro: RR_MUX_ARBITER_LOCK_EN adds the lock input.
// When a lane wins with its lock bit set, the round-robin pointer stays
// where it was. That lane keeps winning for as long as both its req and
// lock bits stay high.
module rr_mux_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         req,
  input  logic [4*WIDTH-1:0] data_in,
`ifdef RR_MUX_ARBITER_LOCK_EN
  input  logic [3:0]         lock,
`endif
  output logic [3:0]         gnt,
  output logic [1:0]         sel,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  input  logic               out_ready
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [1:0]       last;       // index of the most recent round-robin winner
  logic [1:0]       base;       // search starts just after this index
  logic [1:0]       rr_win;
  logic             rr_found;
  logic [1:0]       cand;
  logic [1:0]       winner;
  logic             cap;
  logic             any_req;
  logic             capture;
  logic [WIDTH-1:0] lane [4];

  // Unpack the lanes so the mux is a plain array index.
  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign lane[i] = data_in[i*WIDTH +: WIDTH];
  end

  // A capture is possible when nothing is held, or when the held word
  // leaves in this cycle.
  assign cap     = (state == IDLE) || out_ready;
  assign any_req = |req;
  assign capture = cap && any_req;

  // Round-robin search: base+1, base+2, base+3, then base itself.
  always_comb begin
    rr_win   = base;
    rr_found = 1'b0;
    cand     = base;
    for (int k = 1; k <= 4; k++) begin
      cand = base + 2'(k);
      if (!rr_found && req[cand]) begin
        rr_win   = cand;
        rr_found = 1'b1;
      end
    end
  end

`ifdef RR_MUX_ARBITER_LOCK_EN
  logic       lock_vld;   // a locked lane owns the next opportunity
  logic [1:0] lock_idx;
  logic       lock_hold;

  // The lock survives only while the owner keeps both req and lock high.
  assign lock_hold = lock_vld && req[lock_idx] && lock[lock_idx];
  // After a release, the search resumes from the lane that held the lock.
  assign base      = lock_vld ? lock_idx : last;
  assign winner    = lock_hold ? lock_idx : rr_win;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last     <= 2'd3;
      lock_vld <= 1'b0;
      lock_idx <= 2'd0;
    end else if (capture) begin
      if (lock[winner]) begin
        // The pointer stays put so the locked lane is remembered instead.
        lock_vld <= 1'b1;
        lock_idx <= winner;
      end else begin
        lock_vld <= 1'b0;
        last     <= winner;
      end
    end else if (cap && lock_vld) begin
      // An opportunity with no requests releases the lock. The owner
      // counts as the latest winner.
      lock_vld <= 1'b0;
      last     <= lock_idx;
    end
  end
`else
  assign base   = last;
  assign winner = rr_win;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= 2'd3;
    end else if (capture) begin
      last <= winner;
    end
  end
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (any_req) begin
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (out_ready && !any_req) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs. out_valid is simply the registered state.
  always_comb begin
    gnt       = 4'b0000;
    out_valid = (state == BUSY);
    if (capture) begin
      gnt[winner] = 1'b1;
    end
  end

  // Output datapath. The held word and select stay put until the next
  // capture, including after the return to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data <= '0;
      sel      <= 2'd0;
    end else if (capture) begin
      out_data <= lane[winner];
      sel      <= winner;
    end
  end

endmodule
